// File: rtl/mem_arbiter_nch_pkg.sv
// Shared constants for the N-channel memory arbiter: FSM states, length codes,
// IO region decode and arbitration modes.
package mem_arbiter_nch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_3B = 2'd2;
    localparam logic [1:0] LEN_4B = 2'd3;

    localparam logic [31:0] IO_REGION = 32'h0003_0000;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

endpackage

// File: rtl/mem_arb_grant.sv
// Request vector + mask -> one-hot grant and winner index; owns the round-robin
// pointer, which advances past the winner on every accepted grant.
module mem_arb_grant
    import mem_arbiter_nch_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int PRIO_MODE = PRIO_FIXED,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] mask_i,
    input  logic              take_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   idx_o,
    output logic              any_o
);

    logic [CH_W-1:0]   ptr_q;
    logic [NUM_CH-1:0] eligible;
    int                cand;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        eligible = req_i & ~mask_i;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (PRIO_MODE == PRIO_RR) ? (int'(ptr_q) + i) % NUM_CH : i;
            if (!any_o && eligible[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = CH_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_q <= '0;
        end else if (rdy_in && take_i && any_o) begin
            ptr_q <= (idx_o == CH_W'(NUM_CH - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_nch.sv
// N-channel arbiter and byte serialiser onto a single 8-bit RAM/IO port.
// Grants one requester, issues len+1 byte cycles, collects read bytes, pulses done_o.
module mem_arbiter_nch
    import mem_arbiter_nch_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int PRIO_MODE = PRIO_FIXED
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        wr_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*2-1:0]      len_i,
    input  logic [NUM_CH*32-1:0]     wdata_i,
    output logic [NUM_CH-1:0]        done_o,
    output logic [31:0]              rdata_o,
    output logic                     busy_o,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_e        state_q;
    logic [1:0]        cnt_q;
    logic [1:0]        len_q;
    logic              wr_q;
    logic [31:0]       wbuf_q;
    logic [31:0]       rdata_q;
    logic [NUM_CH-1:0] gnt_q;
    logic [NUM_CH-1:0] done_q;
    logic              busy_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q;
    logic [7:0]        din_hold_q;
    logic              hold_vld_q;

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              take;
    logic [ADDR_W-1:0] addr_sel;
    logic [1:0]        len_sel;
    logic [31:0]       wdata_sel;
    logic              wr_sel;
    logic [7:0]        din_cur;

    assign done_o   = done_q & {NUM_CH{rdy_in}};
    assign mem_wr   = mem_wr_q & rdy_in;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = busy_q;
    assign take     = (state_q == ST_IDLE) && gnt_any;

    mem_arb_grant #(
        .NUM_CH    (NUM_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_grant (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .req_i  (req_i),
        .mask_i (done_o),
        .take_i (take),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    // The byte pending from the last active cycle is captured when a pause starts,
    // so a RAM that keeps running during the pause cannot overwrite it.
    always_comb begin
        addr_sel  = addr_i[int'(gnt_idx) * ADDR_W +: ADDR_W];
        len_sel   = len_i[int'(gnt_idx) * 2 +: 2];
        wdata_sel = wdata_i[int'(gnt_idx) * 32 +: 32];
        wr_sel    = wr_i[gnt_idx];
        din_cur   = hold_vld_q ? din_hold_q : mem_din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            wr_q       <= 1'b0;
            wbuf_q     <= '0;
            rdata_q    <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            din_hold_q <= '0;
            hold_vld_q <= 1'b0;
        end else if (!rdy_in) begin
            if (!hold_vld_q) begin
                din_hold_q <= mem_din;
                hold_vld_q <= 1'b1;
            end
        end else begin
            hold_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        state_q    <= ST_ISSUE;
                        cnt_q      <= '0;
                        len_q      <= len_sel;
                        wr_q       <= wr_sel;
                        gnt_q      <= gnt;
                        busy_q     <= 1'b1;
                        rdata_q    <= '0;
                        mem_a_q    <= addr_sel;
                        mem_wr_q   <= wr_sel;
                        mem_dout_q <= wr_sel ? wdata_sel[7:0] : mem_dout_q;
                        wbuf_q     <= wdata_sel >> 8;
                    end
                end
                ST_ISSUE: begin
                    if (!wr_q && cnt_q != 2'd0) begin
                        rdata_q[{cnt_q - 2'd1, 3'b000} +: 8] <= din_cur;
                    end
                    if (cnt_q == len_q) begin
                        mem_wr_q <= 1'b0;
                        if (wr_q) begin
                            state_q <= ST_DONE;
                            done_q  <= gnt_q;
                        end else begin
                            state_q <= ST_TAIL;
                        end
                    end else begin
                        cnt_q    <= cnt_q + 2'd1;
                        mem_a_q  <= mem_a_q + 1'b1;
                        mem_wr_q <= wr_q;
                        if (wr_q) begin
                            mem_dout_q <= wbuf_q[7:0];
                            wbuf_q     <= wbuf_q >> 8;
                        end
                    end
                end
                ST_TAIL: begin
                    rdata_q[{cnt_q, 3'b000} +: 8] <= din_cur;
                    state_q <= ST_DONE;
                    done_q  <= gnt_q;
                end
                ST_DONE: begin
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Randomised bench for mem_arbiter_nch: a round-robin instance is scored against a
// transaction-level model of memory, latency and grant order; a fixed-priority twin is watched under contention.
module tb_mem_arbiter_nch;
    import mem_arbiter_nch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [1:0]  req, req_fx, wr;
    logic [63:0] addr, wdata;
    logic [3:0]  len;
    logic [1:0]  done, done_fx;
    logic [31:0] rdata, rdata_fx, mem_a, a_fx;
    logic        busy, busy_fx, mem_wr, wr_fx;
    logic [7:0]  mem_din, mem_dout, dout_fx;

    int n_chk = 0;
    int n_err = 0;
    int ptr_m = 0;

    logic [7:0] ram [logic [31:0]];
    logic [7:0] mdl [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter_nch #(.NUM_CH(2), .ADDR_W(32), .PRIO_MODE(PRIO_RR)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_i(req), .wr_i(wr),
        .addr_i(addr), .len_i(len), .wdata_i(wdata), .done_o(done), .rdata_o(rdata),
        .busy_o(busy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_arbiter_nch #(.NUM_CH(2), .ADDR_W(32), .PRIO_MODE(PRIO_FIXED)) dut_fx (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .req_i(req_fx), .wr_i(wr),
        .addr_i(addr), .len_i(len), .wdata_i(wdata), .done_o(done_fx), .rdata_o(rdata_fx),
        .busy_o(busy_fx), .mem_din(8'h00), .mem_dout(dout_fx), .mem_a(a_fx), .mem_wr(wr_fx)
    );

    // Unwritten memory has a fixed pattern; 0x100..0x103 hold 11 22 33 44.
    function automatic logic [7:0] bg(input logic [31:0] a);
        if (a[31:2] == 30'h40) return 8'h11 * (8'(a[1:0]) + 8'd1);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : bg(a);
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : bg(a);
    endfunction

    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input int ch, input logic w, input logic [31:0] a, input logic [1:0] l,
                           input logic [31:0] d, input int ps, input int pl);
        int          nb, base, e;
        bit          seen;
        logic [31:0] exp_rd, ea;
        logic [1:0]  ev;
        nb     = int'(l) + 1;
        base   = w ? nb + 1 : nb + 2;
        exp_rd = '0;
        for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = mdl_rd(a + 32'(k));
        ev   = 2'b01 << ch;
        seen = 1'b0;
        @(posedge clk); #1;
        req = '0;
        wr[ch] = w;
        addr[32*ch +: 32]  = a;
        len[2*ch +: 2]     = l;
        wdata[32*ch +: 32] = d;
        req[ch] = 1'b1;
        for (int c = 1; c <= base + pl + 6 && !seen; c++) begin
            @(posedge clk); #1;
            rdy = !(pl > 0 && c >= ps && c < ps + pl);
            @(negedge clk);
            if (pl > 0 && c >= ps) e = (c < ps + pl) ? ps : c - pl;
            else e = c;
            ea = (e <= nb) ? a + 32'(e - 1) : a + 32'(l);
            chk("mem_a", mem_a, ea);
            chk("mem_wr", mem_wr, w && rdy && e <= nb);
            if (w && rdy && e <= nb) chk("mem_dout", mem_dout, d[8*(e-1) +: 8]);
            chk("busy", busy, 1);
            if (done != 2'b00) begin
                seen = 1'b1;
                chk("done_ch", done, ev);
                chk("latency", 64'(c), 64'(base + pl));
                if (!w) chk("rdata", rdata, exp_rd);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
        req = '0;
        rdy = 1'b1;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        if (w) for (int k = 0; k < nb; k++) mdl[a + 32'(k)] = d[8*k +: 8];
        ptr_m = (ch + 1) % 2;
    endtask

    task automatic contend(input int ngr);
        int          cnt, fx, win;
        logic [31:0] exp_rd;
        cnt = 0;
        fx  = 0;
        @(posedge clk); #1;
        wr = 2'b10;
        addr  = {32'h0000_0310, 32'h0000_0300};
        len   = {2'd0, 2'd1};
        wdata = {32'h0000_005C, 32'h0};
        req = 2'b11;
        req_fx = 2'b11;
        for (int c = 0; c < ngr * 8 + 20 && cnt < ngr; c++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                win = ptr_m;
                chk("rr_order", done, 2'b01 << win);
                if (win == 0) begin
                    exp_rd = {16'h0, mdl_rd(32'h301), mdl_rd(32'h300)};
                    chk("rr_rdata", rdata, exp_rd);
                end else begin
                    mdl[32'h310] = 8'h5C;
                end
                ptr_m = (win + 1) % 2;
                cnt++;
            end
            if (done_fx != 2'b00) begin
                chk("fixed_prio", done_fx, 2'b01);
                fx++;
            end
            @(posedge clk); #1;
        end
        if (cnt < ngr) chk("contend_timeout", 64'(cnt), 64'(ngr));
        chk("fixed_grants", fx >= 2, 1);
        req = '0;
        req_fx = '0;
    endtask

    initial begin
        int          ch, l, base, ps, pl, sel;
        logic        w;
        logic [31:0] a;
        rst = 1'b1; rdy = 1'b1; req = '0; req_fx = '0; wr = '0;
        addr = '0; len = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_dout", mem_dout, 0);
        chk("rst_wr", mem_wr, 0);

        run_txn(0, 1'b0, 32'h100, 2'd3, 32'h0, 0, 0);
        run_txn(1, 1'b1, 32'h200, 2'd1, 32'h0000_AABB, 0, 0);
        run_txn(0, 1'b0, 32'h200, 2'd1, 32'h0, 0, 0);
        run_txn(0, 1'b0, 32'h100, 2'd3, 32'h0, 2, 3);
        run_txn(0, 1'b0, 32'hFFFF_FFFF, 2'd0, 32'h0, 0, 0);
        run_txn(1, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'h0, 0, 0);

        contend(6);
        repeat (8) @(posedge clk);
        run_txn(1, 1'b0, 32'h310, 2'd0, 32'h0, 0, 0);

        // Reset lands in the cycle that writes byte 0 of a 4-byte write.
        @(posedge clk); #1;
        req = 2'b01; wr = 2'b01; addr[31:0] = 32'h400; len[1:0] = 2'd3; wdata[31:0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("rst_mid_wr", mem_wr, 1);
        chk("rst_mid_a", mem_a, 32'h400);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_a", mem_a, 0);
        chk("abort_dout", mem_dout, 0);
        chk("abort_rdata", rdata, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_quiet", {done, mem_wr}, 0);
        end
        mdl[32'h400] = 8'hEF;
        ptr_m = 0;
        run_txn(0, 1'b0, 32'h400, 2'd3, 32'h0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            ch  = $urandom_range(0, 1);
            w   = 1'($urandom_range(0, 1));
            l   = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            if (sel == 0)      a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else if (sel == 1) a = 32'h0003_0010 + 32'($urandom_range(0, 7));
            else               a = 32'h0000_0500 + 32'($urandom_range(0, 31));
            base = w ? l + 2 : l + 3;
            if ($urandom_range(0, 2) == 0) begin
                ps = $urandom_range(1, base);
                pl = $urandom_range(1, 3);
            end else begin
                ps = 0;
                pl = 0;
            end
            run_txn(ch, w, a, 2'(l), $urandom, ps, pl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

endmodule
